// File: rtl/mole_spawner_if.sv
// Mole spawner bus: pause/mole feedback into the spawner, start pulses and round status out.
// Latency: none, this is wiring only.
// Backpressure: none; pause is the only throttle and it is a plain level input.
//
// Signals:
//   pause        - freezes the spawner while high
//   mole_states  - 2 bits per mole from the mole array, 2'b00 = idle
//   start_moles  - one-hot start pulse to the mole array
//   round_over   - round has expired
//   ticks_left   - remaining round ticks
//   spawn_count  - successful spawns, saturating
//   skip_count   - attempts that found every hole busy, saturating
interface mole_spawner_if;
    logic        pause;
    logic [31:0] mole_states;
    logic [15:0] start_moles;
    logic        round_over;
    logic [15:0] ticks_left;
    logic [7:0]  spawn_count;
    logic [7:0]  skip_count;

    // spawner side
    modport master (
        input  pause,
        input  mole_states,
        output start_moles,
        output round_over,
        output ticks_left,
        output spawn_count,
        output skip_count
    );

    // mole array / game controller side
    modport slave (
        output pause,
        output mole_states,
        input  start_moles,
        input  round_over,
        input  ticks_left,
        input  spawn_count,
        input  skip_count
    );
endinterface

// File: rtl/mole_spawner.sv
// Picks a hole with an LFSR, linearly probes past busy holes and fires a one-cycle start pulse.
// Latency: first pulse P+1 ticks after reset release; each busy hole probed adds one tick.
// Backpressure: pause freezes all state and masks start_moles; busy holes are skipped, not queued.
//
// Ports:
//   animation_clk - game tick clock, rising edge
//   rst           - synchronous, active-high reset (overrides pause)
//   bus           - mole_spawner_if.master: pause, mole_states in; start_moles,
//                   round_over, ticks_left, spawn_count, skip_count out
//
// Optional feature macro: MOLE_SPAWN_SPEEDUP_EN
//   When defined, the wait period shrinks by one tick after every 8th spawn,
//   floored at MIN_PERIOD. When undefined the period is fixed at SPAWN_PERIOD.
module mole_spawner #(
    parameter int          SPAWN_PERIOD = 20,
    parameter int          ROUND_TICKS  = 1200,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          MIN_PERIOD   = 4
) (
    input  logic           animation_clk,
    input  logic           rst,
    mole_spawner_if.master bus
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (SPAWN_PERIOD < 4 || SPAWN_PERIOD > 255) begin : g_bad_period
        $error("mole_spawner: SPAWN_PERIOD must be in 4..255");
    end
    if (ROUND_TICKS < 1 || ROUND_TICKS > 65535) begin : g_bad_round
        $error("mole_spawner: ROUND_TICKS must be in 1..65535");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("mole_spawner: LFSR_SEED must be nonzero");
    end
    if (MIN_PERIOD < 4 || MIN_PERIOD > SPAWN_PERIOD) begin : g_bad_min
        $error("mole_spawner: MIN_PERIOD must be in 4..SPAWN_PERIOD");
    end

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_PROBE = 2'd1,
        S_FIRE  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q,  state_nxt;
    logic [7:0]  wait_q,   wait_nxt;
    logic [3:0]  idx_q,    idx_nxt;
    logic [3:0]  probe_q,  probe_nxt;
    logic [15:0] lfsr_q,   lfsr_nxt;
    logic [15:0] ticks_q,  ticks_nxt;
    logic        round_q,  round_nxt;
    logic [7:0]  spawn_q,  spawn_nxt;
    logic [7:0]  skip_q,   skip_nxt;
    logic [15:0] start_q,  start_nxt;

    // Wait-counter reload values: cur_period after a skip, fire_period after
    // a spawn (the latter already reflects a speedup step earned by that spawn).
    logic [7:0]  cur_period;
    logic [7:0]  fire_period;

    logic        lfsr_fb;
    logic        hole_busy;

`ifdef MOLE_SPAWN_SPEEDUP_EN
    logic [7:0] period_q, period_nxt;
    logic [2:0] burst_q,  burst_nxt;   // spawns modulo 8
    logic       fire_evt;

    assign fire_evt   = (state_q == S_FIRE) && !bus.pause;
    assign cur_period = period_q;

    always_comb begin
        period_nxt  = period_q;
        burst_nxt   = burst_q;
        fire_period = period_q;
        // The 8th spawn of a group shortens the very next wait.
        if (burst_q == 3'd7 && period_q > 8'(MIN_PERIOD)) begin
            fire_period = period_q - 8'd1;
        end
        if (fire_evt) begin
            burst_nxt  = burst_q + 3'd1;
            period_nxt = fire_period;
        end
    end

    always_ff @(posedge animation_clk) begin
        if (rst) begin
            period_q <= 8'(SPAWN_PERIOD);
            burst_q  <= 3'd0;
        end else begin
            period_q <= period_nxt;
            burst_q  <= burst_nxt;
        end
    end
`else
    assign cur_period  = 8'(SPAWN_PERIOD);
    assign fire_period = cur_period;
`endif

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        wait_nxt  = wait_q;
        idx_nxt   = idx_q;
        probe_nxt = probe_q;
        lfsr_nxt  = lfsr_q;
        ticks_nxt = ticks_q;
        round_nxt = round_q;
        spawn_nxt = spawn_q;
        skip_nxt  = skip_q;
        start_nxt = start_q;

        // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting toward bit 0
        lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        hole_busy = (bus.mole_states[{idx_q, 1'b0} +: 2] != 2'b00);

        if (!bus.pause) begin
            lfsr_nxt = {lfsr_fb, lfsr_q[15:1]};

            case (state_q)
                S_WAIT: begin
                    if (wait_q == 8'd0) begin
                        idx_nxt   = lfsr_q[3:0];
                        probe_nxt = 4'd0;
                        state_nxt = S_PROBE;
                    end else begin
                        wait_nxt = wait_q - 8'd1;
                    end
                end

                S_PROBE: begin
                    if (!hole_busy) begin
                        // Register the pulse so it is on the wire for the whole FIRE tick.
                        state_nxt = S_FIRE;
                        start_nxt = 16'd1 << idx_q;
                    end else begin
                        idx_nxt = idx_q + 4'd1;   // wraps 15 -> 0
                        if (probe_q == 4'd15) begin
                            if (skip_q != 8'hFF) begin
                                skip_nxt = skip_q + 8'd1;
                            end
                            wait_nxt  = cur_period - 8'd1;
                            state_nxt = S_WAIT;
                        end else begin
                            probe_nxt = probe_q + 4'd1;
                        end
                    end
                end

                S_FIRE: begin
                    start_nxt = 16'd0;
                    if (spawn_q != 8'hFF) begin
                        spawn_nxt = spawn_q + 8'd1;
                    end
                    wait_nxt  = fire_period - 8'd1;
                    state_nxt = S_WAIT;
                end

                S_DONE: begin
                    // terminal: only rst leaves
                end
            endcase

            // Round expiry wins over whatever the FSM decided this tick. A
            // pulse already on the wire has completed (and is counted); an
            // in-flight probe is dropped without firing or counting a skip.
            if (state_q != S_DONE) begin
                ticks_nxt = ticks_q - 16'd1;
                if (ticks_q == 16'd1) begin
                    state_nxt = S_DONE;
                    round_nxt = 1'b1;
                    start_nxt = 16'd0;
                    skip_nxt  = skip_q;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge animation_clk) begin
        if (rst) begin
            state_q <= S_WAIT;
            wait_q  <= 8'(SPAWN_PERIOD) - 8'd1;
            idx_q   <= 4'd0;
            probe_q <= 4'd0;
            lfsr_q  <= LFSR_SEED;
            ticks_q <= 16'(ROUND_TICKS);
            round_q <= 1'b0;
            spawn_q <= 8'd0;
            skip_q  <= 8'd0;
            start_q <= 16'd0;
        end else begin
            state_q <= state_nxt;
            wait_q  <= wait_nxt;
            idx_q   <= idx_nxt;
            probe_q <= probe_nxt;
            lfsr_q  <= lfsr_nxt;
            ticks_q <= ticks_nxt;
            round_q <= round_nxt;
            spawn_q <= spawn_nxt;
            skip_q  <= skip_nxt;
            start_q <= start_nxt;
        end
    end

    // Pause masks the pulse immediately; the FSM stays in FIRE and replays
    // the full pulse once pause drops.
    assign bus.start_moles = bus.pause ? 16'd0 : start_q;
    assign bus.round_over  = round_q;
    assign bus.ticks_left  = ticks_q;
    assign bus.spawn_count = spawn_q;
    assign bus.skip_count  = skip_q;

endmodule
